// File: rtl/bsearch_pkg.sv
// Shared types and default sizing for the binary-search controller and its
// siblings.
package bsearch_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        COMPARE = 2'd2,
        FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/bsearch_ctrl.sv
// Binary-search controller: walks a sorted synchronous-read RAM through an
// external comparator and reports hit/miss with the matching address.
module bsearch_ctrl
    import bsearch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] key_in,
    input  logic              gt,
    input  logic              eq,
    input  logic              lt,
    output logic [DATA_W-1:0] data_t,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_addr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_key;
    logic [ADDR_W-1:0] r_low;
    logic [ADDR_W-1:0] r_high;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_match;
    logic              r_found;
    logic              r_err;

    logic              w_onehot;
    logic              w_gt_miss;
    logic              w_lt_miss;
    logic [ADDR_W-1:0] w_mid_inc;
    logic [ADDR_W-1:0] w_mid_dec;

    // Midpoint evaluated one bit wider so low+high cannot wrap.
    function automatic logic [ADDR_W-1:0] mid_of(input logic [ADDR_W-1:0] lo,
                                                 input logic [ADDR_W-1:0] hi);
        logic [ADDR_W:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[ADDR_W:1];
    endfunction

    assign w_onehot  = $onehot({gt, eq, lt});
    assign w_gt_miss = (r_addr == r_high);
    assign w_lt_miss = (r_addr == r_low);
    assign w_mid_inc = r_addr + ADDR_W'(1);
    assign w_mid_dec = r_addr - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = READ;
            READ:    w_state_nxt = COMPARE;
            COMPARE: begin
                if (!w_onehot || eq)  w_state_nxt = FINISH;
                else if (gt)          w_state_nxt = w_gt_miss ? FINISH : READ;
                else                  w_state_nxt = w_lt_miss ? FINISH : READ;
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The probe address is loaded on entry to READ so the RAM captures it at
    // the end of READ and its data is valid throughout COMPARE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key   <= '0;
            r_low   <= '0;
            r_high  <= '0;
            r_addr  <= '0;
            r_match <= '0;
            r_found <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key   <= key_in;
                        r_low   <= '0;
                        r_high  <= TOP;
                        r_addr  <= mid_of('0, TOP);
                        r_match <= '0;
                        r_found <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (!w_onehot) begin
                        r_err   <= 1'b1;
                        r_found <= 1'b0;
                    end else if (eq) begin
                        r_found <= 1'b1;
                        r_match <= r_addr;
                    end else if (gt && !w_gt_miss) begin
                        r_low  <= w_mid_inc;
                        r_addr <= mid_of(w_mid_inc, r_high);
                    end else if (lt && !w_lt_miss) begin
                        r_high <= w_mid_dec;
                        r_addr <= mid_of(r_low, w_mid_dec);
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_t     = r_key;
    assign ram_addr   = r_addr;
    assign ram_rd     = (r_state == READ);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == FINISH);
    assign found      = r_found;
    assign match_addr = r_match;
    assign err        = r_err;

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Bench for bsearch_ctrl: behavioural sync RAM and comparator, directed
// scenarios plus randomized searches against a reference search model.
module tb_bsearch_ctrl;
    import bsearch_pkg::*;

    localparam int DW    = DATA_W_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] key_in = '0;
    logic          gt, eq, lt;
    logic [DW-1:0] data_t;
    logic [AW-1:0] ram_addr;
    logic          ram_rd, busy, done, found, err;
    logic [AW-1:0] match_addr;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ramout = '0;
    logic          force_bad = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference model results
    int m_probes;
    bit m_found;
    int m_match;
    int m_mids[$];

    // observed results
    int            o_done;
    bit            o_found;
    int            o_match;
    bit            o_err;
    logic [DW-1:0] o_data_t;
    int            o_mids[$];
    int            o_busy_bad;

    bsearch_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .gt(gt), .eq(eq), .lt(lt), .data_t(data_t), .ram_addr(ram_addr),
        .ram_rd(ram_rd), .busy(busy), .done(done), .found(found),
        .match_addr(match_addr), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ramout <= mem[ram_addr];

    always_comb begin
        gt = force_bad | (data_t > ramout);
        eq = force_bad | (data_t == ramout);
        lt = !force_bad && (data_t < ramout);
    end

    function automatic longint pack_mids(input int q[$]);
        longint v = 0;
        foreach (q[i]) v = (v << 6) | longint'(q[i] + 1);
        return v;
    endfunction

    function automatic longint pack6(input int a, b, c, d, e, f);
        int q[$];
        if (a >= 0) q.push_back(a);
        if (b >= 0) q.push_back(b);
        if (c >= 0) q.push_back(c);
        if (d >= 0) q.push_back(d);
        if (e >= 0) q.push_back(e);
        if (f >= 0) q.push_back(f);
        return pack_mids(q);
    endfunction

    task automatic fill_odd();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(2 * i + 1);
    endtask

    // Plain binary search over the sorted array, as the search rules describe.
    task automatic model_search(input int key);
        int lo = 0, hi = DEPTH - 1, mid;
        m_probes = 0; m_found = 0; m_match = 0; m_mids.delete();
        forever begin
            mid = (lo + hi) / 2;
            m_probes++;
            m_mids.push_back(mid);
            if (int'(mem[mid]) == key) begin m_found = 1; m_match = mid; break; end
            else if (key > int'(mem[mid])) begin
                if (mid == hi) break;
                lo = mid + 1;
            end else begin
                if (mid == lo) break;
                hi = mid - 1;
            end
        end
    endtask

    task automatic run_search(input int key, input int inj_cycle, input int inj_key);
        o_mids.delete(); o_done = -1; o_busy_bad = 0;
        o_found = 0; o_match = 0; o_err = 0; o_data_t = '0;
        @(negedge clk);
        start = 1'b1; key_in = DW'(key);
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == inj_cycle);
            if (c == inj_cycle) key_in = DW'(inj_key);
            if (ram_rd) o_mids.push_back(int'(ram_addr));
            if (done) begin
                o_done = c; o_found = found; o_match = int'(match_addr);
                o_err = err; o_data_t = data_t;
                break;
            end
            if (!busy) o_busy_bad++;
        end
        start = 1'b0;
        if (o_done < 0) begin
            total++; bad++;
            $display("FAIL timeout key=%0d: no done within 20 cycles", key);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({done, busy, found, err, ram_rd, match_addr, ram_addr, data_t} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got done=%b busy=%b found=%b err=%b rd=%b match=%0d addr=%0d data_t=%0d want all 0",
                     done, busy, found, err, ram_rd, match_addr, ram_addr, data_t);
        end
        reset = 1'b0;
    endtask

    task automatic test_hit_interior();
        run_search(33, 0, 0);
        total++; if (o_done !== 11) begin bad++; $display("FAIL hit33_done got=%0d want=11", o_done); end
        total++; if (o_found !== 1'b1 || o_match !== 16) begin bad++; $display("FAIL hit33_result got found=%0d match=%0d want 1/16", o_found, o_match); end
        total++; if (pack_mids(o_mids) !== pack6(15, 23, 19, 17, 16, -1)) begin bad++; $display("FAIL hit33_mids got=%h want=%h", pack_mids(o_mids), pack6(15, 23, 19, 17, 16, -1)); end
        total++; if (o_err !== 1'b0 || o_busy_bad !== 0) begin bad++; $display("FAIL hit33_err_busy got err=%0d busy_gaps=%0d want 0/0", o_err, o_busy_bad); end
    endtask

    task automatic test_hit_top();
        run_search(63, 0, 0);
        total++; if (o_done !== 13) begin bad++; $display("FAIL hit63_done got=%0d want=13", o_done); end
        total++; if (o_found !== 1'b1 || o_match !== 31) begin bad++; $display("FAIL hit63_result got found=%0d match=%0d want 1/31", o_found, o_match); end
        total++; if (pack_mids(o_mids) !== pack6(15, 23, 27, 29, 30, 31)) begin bad++; $display("FAIL hit63_mids got=%h want=%h", pack_mids(o_mids), pack6(15, 23, 27, 29, 30, 31)); end
    endtask

    task automatic test_miss_edges();
        run_search(0, 0, 0);
        total++; if (o_done !== 11) begin bad++; $display("FAIL miss0_done got=%0d want=11", o_done); end
        total++; if (o_found !== 1'b0 || o_match !== 0) begin bad++; $display("FAIL miss0_result got found=%0d match=%0d want 0/0", o_found, o_match); end
        run_search(64, 0, 0);
        total++; if (o_done !== 13) begin bad++; $display("FAIL miss64_done got=%0d want=13", o_done); end
        total++; if (o_found !== 1'b0 || o_match !== 0) begin bad++; $display("FAIL miss64_result got found=%0d match=%0d want 0/0", o_found, o_match); end
        run_search(32, 0, 0);
        total++; if (o_found !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL miss32_result got found=%0d err=%0d want 0/0", o_found, o_err); end
    endtask

    task automatic test_back_to_back();
        run_search(1, 3, 5);
        total++; if (o_data_t !== DW'(1)) begin bad++; $display("FAIL busy_data_t got=%0d want=1", o_data_t); end
        total++; if (o_found !== 1'b1 || o_match !== 0 || o_done !== 11) begin bad++; $display("FAIL busy_key1 got found=%0d match=%0d done=%0d want 1/0/11", o_found, o_match, o_done); end
        run_search(33, 0, 0);
        total++; if (o_found !== 1'b1 || o_match !== 16 || o_done !== 11) begin bad++; $display("FAIL b2b_key33 got found=%0d match=%0d done=%0d want 1/16/11", o_found, o_match, o_done); end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        @(negedge clk);
        start = 1'b1; key_in = DW'(33);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_seen++;
            if (c == 4) reset = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({done, busy, found, err, ram_rd, match_addr, ram_addr, data_t} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got done=%b busy=%b found=%b err=%b rd=%b match=%0d addr=%0d data_t=%0d want all 0",
                     done, busy, found, err, ram_rd, match_addr, ram_addr, data_t);
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d activity cycles want=0", done_seen); end
        run_search(33, 0, 0);
        total++;
        if (o_found !== 1'b1 || o_match !== 16 || o_done !== 11 || pack_mids(o_mids) !== pack6(15, 23, 19, 17, 16, -1)) begin
            bad++;
            $display("FAIL midreset_rerun got found=%0d match=%0d done=%0d want 1/16/11", o_found, o_match, o_done);
        end
    endtask

    task automatic test_illegal_flags();
        int dcyc = -1;
        @(negedge clk);
        start = 1'b1; key_in = DW'(33);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            force_bad = (c == 2);
            if (done) begin
                dcyc = c;
                total++; if (err !== 1'b1 || found !== 1'b0) begin bad++; $display("FAIL illegal_result got err=%0d found=%0d want 1/0", err, found); end
                break;
            end
            @(posedge clk);
        end
        force_bad = 1'b0;
        total++; if (dcyc !== 3) begin bad++; $display("FAIL illegal_done got=%0d want=3", dcyc); end
        run_search(33, 0, 0);
        total++; if (o_err !== 1'b0 || o_found !== 1'b1) begin bad++; $display("FAIL illegal_clear got err=%0d found=%0d want 0/1", o_err, o_found); end
    endtask

    task automatic test_random();
        int v, key;
        for (int r = 0; r < 4; r++) begin
            v = $urandom_range(0, 3);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = DW'(v);
                v = v + $urandom_range(0, 12);
                if (v > 255) v = 255;
            end
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 1) == 1) key = int'(mem[$urandom_range(0, DEPTH - 1)]);
                else key = $urandom_range(0, 255);
                model_search(key);
                run_search(key, 0, 0);
                total++;
                if (o_done !== 2 * m_probes + 1 || o_found !== m_found ||
                    (m_found && o_match !== m_match) || (!m_found && o_match !== 0) ||
                    o_err !== 1'b0 || pack_mids(o_mids) !== pack_mids(m_mids)) begin
                    bad++;
                    $display("FAIL rand_key%0d got done=%0d found=%0d match=%0d err=%0d mids=%h want done=%0d found=%0d match=%0d err=0 mids=%h",
                             key, o_done, o_found, o_match, o_err, pack_mids(o_mids),
                             2 * m_probes + 1, m_found, m_found ? m_match : 0, pack_mids(m_mids));
                end
            end
        end
    endtask

    initial begin
        fill_odd();
        test_reset();
        test_hit_interior();
        test_hit_top();
        test_miss_edges();
        test_back_to_back();
        test_reset_mid();
        test_illegal_flags();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
